// File: rtl/wb_slot_scheduler_pkg.sv
// rtl/wb_slot_scheduler_pkg.sv - shared sequence-number, branch and writeback request types
package wb_slot_scheduler_pkg;
  localparam int SQN_W = 7;
  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic taken;
    SqN   sqN;
  } BranchProv;

  localparam int WB_MAX_LAT = 16;
  localparam int WB_LAT_W   = $clog2(WB_MAX_LAT + 1);

  typedef struct packed {
    logic                valid;
    SqN                  sqN;
    logic [WB_LAT_W-1:0] lat;
    logic [WB_LAT_W-1:0] occ;
  } WbReq;

  // Sequence numbers wrap, so age is the sign of the modular difference.
  function automatic logic sqnOlder(input SqN a, input SqN b);
    SqN d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

  function automatic logic sqnYounger(input SqN a, input SqN b);
    SqN d;
    d = a - b;
    return (d != '0) && !d[SQN_W-1];
  endfunction
endpackage

// File: rtl/wb_age_select.sv
// rtl/wb_age_select.sv - combinational oldest-of-N picker, lowest index wins ties
module wb_age_select
  import wb_slot_scheduler_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] IN_valid,
  input  SqN           IN_sqN [N],
  output logic [N-1:0] OUT_sel
);

  always_comb begin
    OUT_sel = '0;
    for (int i = 0; i < N; i++) begin
      OUT_sel[i] = IN_valid[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && IN_valid[j] &&
            (sqnOlder(IN_sqN[j], IN_sqN[i]) || (IN_sqN[j] == IN_sqN[i] && j < i)))
          OUT_sel[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_slot_scheduler.sv
// rtl/wb_slot_scheduler.sv - result-bus slot reservation and issue grant for multi-cycle units
module wb_slot_scheduler
  import wb_slot_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MAX_LAT = WB_MAX_LAT,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  BranchProv          IN_branch,
  input  logic [NUM_REQ-1:0] IN_reqValid,
  input  SqN                 IN_reqSqN [NUM_REQ],
  input  logic [LAT_W-1:0]   IN_reqLat [NUM_REQ],
  input  logic [LAT_W-1:0]   IN_reqOcc [NUM_REQ],
  input  logic               IN_stall,
  output logic [NUM_REQ-1:0] OUT_grant,
  output logic [NUM_REQ-1:0] OUT_unitBusy,
  output logic               OUT_intBlock,
  output logic [MAX_LAT-1:0] OUT_resVec
);

  logic [MAX_LAT-1:0] res;
  logic [MAX_LAT-1:0] resNext;
  logic [LAT_W-1:0]   busyCnt [NUM_REQ];
  logic [NUM_REQ-1:0] latOk;
  logic [NUM_REQ-1:0] slotFree;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] peers [NUM_REQ];
  logic [NUM_REQ-1:0] pick  [NUM_REQ];
  logic [NUM_REQ-1:0] grantRaw;

  always_comb begin
    latOk    = '0;
    slotFree = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      latOk[i]    = (IN_reqLat[i] != '0) && (IN_reqLat[i] <= LAT_W'(MAX_LAT));
      // A latency of MAX_LAT lands beyond the tracked window and is always free.
      slotFree[i] = 1'b1;
      for (int k = 1; k < MAX_LAT; k++)
        if (IN_reqLat[i] == LAT_W'(k) && res[k])
          slotFree[i] = 1'b0;
      eligible[i] = IN_reqValid[i] && !IN_stall && (busyCnt[i] == '0) && latOk[i] &&
                    slotFree[i] &&
                    !(IN_branch.taken && sqnYounger(IN_reqSqN[i], IN_branch.sqN));
    end
  end

  // Each requester picks within its own latency group; OR-ing the picks
  // yields exactly one winner per distinct latency.
  for (genvar g = 0; g < NUM_REQ; g++) begin : gGroup
    always_comb begin
      peers[g] = '0;
      for (int j = 0; j < NUM_REQ; j++)
        peers[g][j] = eligible[j] && (IN_reqLat[j] == IN_reqLat[g]);
    end

    wb_age_select #(.N(NUM_REQ)) uAgeSelect (
      .IN_valid(peers[g]),
      .IN_sqN  (IN_reqSqN),
      .OUT_sel (pick[g])
    );
  end

  always_comb begin
    grantRaw = '0;
    for (int g = 0; g < NUM_REQ; g++)
      grantRaw = grantRaw | pick[g];
  end

  assign OUT_grant    = rst ? '0 : grantRaw;
  assign OUT_intBlock = !rst && res[1];
  assign OUT_resVec   = res;

  always_comb begin
    OUT_unitBusy = '0;
    for (int i = 0; i < NUM_REQ; i++)
      OUT_unitBusy[i] = !rst && (busyCnt[i] != '0);
  end

  always_comb begin
    resNext = res >> 1;
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < MAX_LAT; k++)
        if (OUT_grant[i] && IN_reqLat[i] == LAT_W'(k + 1))
          resNext[k] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        busyCnt[i] <= '0;
    end else begin
      res <= resNext;
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (!IN_reqValid[i] || latOk[i]);
        if (OUT_grant[i] && IN_reqOcc[i] != '0)
          busyCnt[i] <= IN_reqOcc[i] - LAT_W'(1);
        else if (busyCnt[i] != '0)
          busyCnt[i] <= busyCnt[i] - LAT_W'(1);
        else
          busyCnt[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_slot_scheduler.sv
// tb/tb_wb_slot_scheduler.sv - directed self-checking bench for wb_slot_scheduler
module tb_wb_slot_scheduler;
  import wb_slot_scheduler_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int MAX_LAT = 16;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  logic               clk = 1'b0;
  logic               rst;
  BranchProv          branch;
  logic [NUM_REQ-1:0] valid;
  SqN                 sqN [NUM_REQ];
  logic [LAT_W-1:0]   lat [NUM_REQ];
  logic [LAT_W-1:0]   occ [NUM_REQ];
  logic               stall;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] unitBusy;
  logic               intBlock;
  logic [MAX_LAT-1:0] resVec;

  int total = 0;
  int bad   = 0;

  wb_slot_scheduler #(.NUM_REQ(NUM_REQ), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .IN_branch   (branch),
    .IN_reqValid (valid),
    .IN_reqSqN   (sqN),
    .IN_reqLat   (lat),
    .IN_reqOcc   (occ),
    .IN_stall    (stall),
    .OUT_grant   (grant),
    .OUT_unitBusy(unitBusy),
    .OUT_intBlock(intBlock),
    .OUT_resVec  (resVec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearReqs();
    valid  = '0;
    stall  = 1'b0;
    branch = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sqN[i] = '0;
      lat[i] = 5'd1;
      occ[i] = '0;
    end
  endtask

  initial begin
    rst = 1'b1;
    clearReqs();

    // Reset with every request valid
    valid = 3'b111;
    for (int i = 0; i < NUM_REQ; i++) begin
      lat[i] = 5'd3;
      sqN[i] = SqN'(i);
    end
    tick(); #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_res", 32'(resVec), 32'h0);
    chk("rst_intblk", 32'(intBlock), 32'h0);
    chk("rst_busy", 32'(unitBusy), 32'h0);
    tick();
    rst = 1'b0;
    valid = 3'b001; #1;
    chk("post_rst_grant", 32'(grant), 32'h1);
    tick(); #1;
    chk("res_t1", 32'(resVec), 32'h4);
    chk("intblk_t1", 32'(intBlock), 32'h0);

    // Reservation window
    valid = 3'b010; sqN[1] = 7'd2; lat[1] = 5'd2; #1;
    chk("lat2_taken", 32'(grant), 32'h0);
    lat[1] = 5'd3; #1;
    chk("lat3_free", 32'(grant), 32'h2);
    valid = '0; #1;
    tick(); #1;
    chk("res_t2", 32'(resVec), 32'h2);
    chk("intblk_t2", 32'(intBlock), 32'h1);
    tick(); #1;
    chk("res_t3", 32'(resVec), 32'h1);
    chk("intblk_t3", 32'(intBlock), 32'h0);
    tick(); #1;
    chk("res_t4", 32'(resVec), 32'h0);

    // Same-slot conflicts
    clearReqs();
    valid = 3'b101; sqN[0] = 7'd10; sqN[2] = 7'd5; lat[0] = 5'd4; lat[2] = 5'd4; #1;
    chk("oldest_wins", 32'(grant), 32'h4);
    sqN[0] = 7'd2; sqN[2] = 7'd126; #1;
    chk("oldest_wrap", 32'(grant), 32'h4);
    valid = 3'b011; sqN[0] = 7'd7; sqN[1] = 7'd7; lat[1] = 5'd4; #1;
    chk("tie_low_idx", 32'(grant), 32'h1);
    valid = 3'b111; sqN[0] = 7'd2; sqN[1] = 7'd50; lat[1] = 5'd5; #1;
    chk("diff_lat_both", 32'(grant), 32'h6);
    tick(); #1;
    chk("res_two_slots", 32'(resVec), 32'h18);
    valid = '0;
    for (int c = 0; c < 5; c++) tick();
    #1;
    chk("res_drain1", 32'(resVec), 32'h0);

    // Maximum latency boundary
    clearReqs();
    valid = 3'b001; lat[0] = 5'd16; sqN[0] = 7'd1; #1;
    chk("maxlat_grant", 32'(grant), 32'h1);
    tick(); #1;
    chk("maxlat_res", 32'(resVec), 32'h8000);
    valid = 3'b011; lat[1] = 5'd15; sqN[1] = 7'd0; #1;
    chk("maxlat_again", 32'(grant), 32'h1);
    tick(); #1;
    chk("maxlat_res2", 32'(resVec), 32'hC000);
    valid = '0;
    for (int c = 0; c < 16; c++) tick();
    #1;
    chk("res_drain2", 32'(resVec), 32'h0);

    // Non-pipelined unit occupancy
    clearReqs();
    valid = 3'b010; lat[1] = 5'd8; occ[1] = 5'd6; sqN[1] = 7'd3; #1;
    chk("occ_grant", 32'(grant), 32'h2);
    tick();
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("occ_busy_c%0d", c), 32'(unitBusy), 32'h2);
      chk($sformatf("occ_block_c%0d", c), 32'(grant), 32'h0);
      tick();
    end
    #1;
    chk("occ_free_busy", 32'(unitBusy), 32'h0);
    chk("occ_regrant", 32'(grant), 32'h2);
    valid = '0; #1;
    for (int c = 0; c < 8; c++) tick();
    #1;
    chk("res_drain3", 32'(resVec), 32'h0);

    // Branch flush
    clearReqs();
    valid = 3'b100; lat[2] = 5'd5; sqN[2] = 7'd0; #1;
    chk("pre_flush_grant", 32'(grant), 32'h4);
    tick();
    valid = 3'b011; branch.taken = 1'b1; branch.sqN = 7'd20;
    sqN[0] = 7'd21; lat[0] = 5'd2; sqN[1] = 7'd19; lat[1] = 5'd2; #1;
    chk("flush_kill_young", 32'(grant), 32'h2);
    tick(); #1;
    chk("flush_res_kept", 32'(resVec), 32'hA);
    valid = 3'b001; sqN[0] = 7'd20; lat[0] = 5'd4; #1;
    chk("flush_equal_sqn", 32'(grant), 32'h1);
    branch.taken = 1'b0; sqN[0] = 7'd21; #1;
    chk("after_flush", 32'(grant), 32'h1);
    valid = '0; #1;
    tick(); #1;
    chk("flush_res_shift", 32'(resVec), 32'h5);
    for (int c = 0; c < 3; c++) tick();
    #1;
    chk("res_drain4", 32'(resVec), 32'h0);

    // Stall keeps time moving without granting
    clearReqs();
    valid = 3'b010; lat[1] = 5'd5; occ[1] = 5'd4; sqN[1] = 7'd1; #1;
    chk("stall_setup_grant", 32'(grant), 32'h2);
    tick();
    valid = '0; occ[1] = '0;
    tick(); #1;
    chk("stall_res0", 32'(resVec), 32'h8);
    chk("stall_busy0", 32'(unitBusy), 32'h2);
    stall = 1'b1; valid = 3'b111;
    lat[0] = 5'd1; lat[1] = 5'd2; lat[2] = 5'd6; #1;
    chk("stall_grant0", 32'(grant), 32'h0);
    tick(); #1;
    chk("stall_grant1", 32'(grant), 32'h0);
    chk("stall_res1", 32'(resVec), 32'h4);
    chk("stall_busy1", 32'(unitBusy), 32'h2);
    tick(); #1;
    chk("stall_grant2", 32'(grant), 32'h0);
    chk("stall_res2", 32'(resVec), 32'h2);
    chk("stall_intblk", 32'(intBlock), 32'h1);
    chk("stall_busy2", 32'(unitBusy), 32'h0);
    tick(); #1;
    chk("stall_res3", 32'(resVec), 32'h1);
    stall = 1'b0; valid = 3'b011; lat[1] = 5'd7; occ[1] = 5'd5; #1;
    chk("unstall_grant", 32'(grant), 32'h3);
    tick(); #1;
    chk("unstall_res", 32'(resVec), 32'h41);
    chk("unstall_busy", 32'(unitBusy), 32'h2);

    // Reset in the middle of activity
    rst = 1'b1; #1;
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_busy", 32'(unitBusy), 32'h0);
    chk("midrst_intblk", 32'(intBlock), 32'h0);
    tick(); #1;
    chk("midrst_res", 32'(resVec), 32'h0);
    rst = 1'b0; valid = '0; #1;
    chk("midrst_busy_after", 32'(unitBusy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_slot_scheduler.md
Name: wb_slot_scheduler

Overview:
- Central scheduler for the shared integer/FP result bus.
- Multi-cycle execution units (FMUL, FDIV, IDIV, ...) each have an issue queue. Every cycle that queue requests to issue one op with a known latency.
- The scheduler grants only requests whose writeback cycle is free. It keeps a reservation shift register of future bus cycles and tracks busy counters for non-pipelined units.
- It replaces ad-hoc per-queue reservation logic and drives the do-not-issue inputs of all issue queues, including the single-cycle INT queue.

Parameters:
- NUM_REQ, 3: number of requesting issue queues / slow units.
- MAX_LAT, 16: largest supported result latency in cycles; must be ≥2.
- LAT_W, $clog2(MAX_LAT+1): width of the latency and occupancy fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IN_branch  in  BranchProv  mispredict flush (taken, sqN)
- IN_reqValid  in  NUM_REQ x 1  queue i wants to issue this cycle
- IN_reqSqN  in  NUM_REQ x SqN  sqN of the candidate op
- IN_reqLat  in  NUM_REQ x LAT_W  cycles from issue to result-bus cycle, 1..MAX_LAT
- IN_reqOcc  in  NUM_REQ x LAT_W  cycles the unit stays unable to accept; 0 = pipelined
- IN_stall  in  1  backend stall; no grants are given while high
- OUT_grant  out  NUM_REQ x 1  request i may issue this cycle (combinational)
- OUT_unitBusy  out  NUM_REQ x 1  unit i busy, fed to doNotIssue (registered-state-derived)
- OUT_intBlock  out  1  bus taken next cycle; single-cycle INT ops must not issue
- OUT_resVec  out  MAX_LAT  reservation vector, debug/verification only

Behaviour:
- State:
  - res[MAX_LAT-1:0]: res[k]=1 means the bus is owned by a slow op in cycle t+k.
  - busyCnt[i] (LAT_W bits) per requester.
- Reset: res=0, busyCnt=0. While rst is high, OUT_grant=0, OUT_unitBusy=0, OUT_intBlock=0.
- Eligibility of request i, all must hold:
  - IN_reqValid[i]
  - !IN_stall
  - busyCnt[i]==0
  - 1≤IN_reqLat[i]≤MAX_LAT
  - res[IN_reqLat[i]] is 0; for L==MAX_LAT the bit is treated as 0
  - not (IN_branch.taken and $signed(IN_reqSqN[i]-IN_branch.sqN)>0)
- Conflict: eligible requests with equal latency compete for one slot.
  - The oldest wins, i.e. smallest sqN by signed difference. Ties go to the lowest index.
  - Requests with different latencies are all granted in the same cycle.
- Latency 0 or >MAX_LAT is never granted; an assertion fires in simulation.
- Combinational paths: OUT_grant depends only on current inputs and registered state. Requesters must not derive IN_reqValid from OUT_grant.
- Update on clock edge when not in reset:
  - res_next = (res >> 1) | OR over granted i of (1 << (IN_reqLat[i]-1)).
  - busyCnt[i]_next:
    - IN_reqOcc[i]-1 if granted and IN_reqOcc[i]>0
    - busyCnt[i]-1 if busyCnt[i]>0
    - else 0
- OUT_unitBusy[i] = (busyCnt[i]!=0).
- OUT_intBlock = res[1]. A one-cycle op issued now would write back in cycle t+1, which is already owned.
- Branch flush:
  - Existing reservations and busy counters are NOT cleared; in-flight killed ops release them conservatively.
  - Younger requests are suppressed only in the flush cycle.
- IN_stall high: no grants. res still shifts and busy counters still count down, because in-flight ops keep progressing.
- Reset mid-operation: all state is cleared on the next edge. Outstanding units are assumed flushed by the global reset.

Decomposition:
- Shared package (existing): SqN, BranchProv.
- Add to the package: localparam WB_MAX_LAT and a WbReq struct {valid, sqN, lat, occ} so issue queues can build requests.
- One sub-module: wb_age_select, a combinational oldest-of-N picker over (valid, sqN) with lowest-index tie break. It is instantiated once per distinct latency value present, or applied to pairwise masks.
- The remaining logic stays flat.

Test Plan:
1. Reset: assert rst for 2 cycles with all requests valid, lat=3 → OUT_grant=0, OUT_resVec=0, OUT_intBlock=0. After release, request 0 with lat=3 is granted.
2. Reservation: grant req0 with lat=3 at cycle t → res=0b100 at t+1, 0b010 at t+2 (OUT_intBlock=1 at t+2), 0 at t+4. Req1 with lat=2 at t+1 is denied; with lat=3 at t+1 it is granted.
3. Same-slot conflict: req0 sqN=10, req2 sqN=5, both lat=4 → only req2 granted. With sqN wrap, req0 sqN=2 vs req2 sqN=126 (7-bit) → req2 granted as the older.
4. Non-pipelined unit: req1 granted with lat=8, occ=6 → OUT_unitBusy[1]=1 for exactly 5 cycles. A new req1 is ignored during that time and granted on the 6th cycle.
5. Branch flush: IN_branch.taken sqN=20; req0 sqN=21 and req1 sqN=19, both lat=2 → only req1 granted. Pre-existing res bits are unchanged.
6. Stall: res=0b1000 and IN_stall=1 for 3 cycles with valid requests → no grants, res shifts to 0b0001 as usual, busy counters still decrement.
